line_req_arb: RTL and testbench

Two-requester line-transfer arbiter sitting directly upstream of the core's AXI master. It accepts 128-bit cache-line requests from the I-cache refill port (read only) and the D-cache refill/writeback port (read or write). It grants one at a time, issues a single-cycle request pulse with stable address, direction and data to the AXI master, and waits for the master's completion pulse. It then returns read data and a one-cycle acknowledge to the owning requester.

---
 rtl/line_req_arb_pkg.sv | 24 ++
 rtl/line_req_arb_if.sv | 45 ++++
 rtl/line_arb_grant.sv | 43 ++++
 rtl/line_req_arb.sv | 99 +++++++++
 tb/tb_line_req_arb.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/line_req_arb_pkg.sv
// Shared encodings for the line request arbiter.
// Covers FSM states, grant owner, transfer direction and line-address alignment.
package line_req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // 16-byte lines: the low four address bits are always cleared on issue
  localparam int          LINE_OFS_W      = 4;
  localparam logic [63:0] LINE_ALIGN_MASK = ~((64'd1 << LINE_OFS_W) - 64'd1);

endpackage

// File: rtl/line_req_arb_if.sv
// Requester, AXI-master and status signals of the line arbiter bundled into one interface.
// The master modport is the arbiter's view; slave is the surrounding core / AXI master.
interface line_req_arb_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [LINE_W-1:0] i_rdata_o;

  logic              d_req_i;
  logic              d_rw_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [LINE_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic [LINE_W-1:0] d_rdata_o;

  logic              Rvcore_valid_req_o;
  logic              Rvcore_rw_o;
  logic [ADDR_W-1:0] Rvcore_addr_o;
  logic [LINE_W-1:0] Rvcore_data_o;
  logic [LINE_W-1:0] axi_data_i;
  logic              axi_rd_over_i;
  logic              axi_wr_over_i;

  logic              busy_o;
  logic              err_o;

  modport master (
    input  i_req_i, i_addr_i, d_req_i, d_rw_i, d_addr_i, d_wdata_i,
    input  axi_data_i, axi_rd_over_i, axi_wr_over_i,
    output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o,
    output Rvcore_valid_req_o, Rvcore_rw_o, Rvcore_addr_o, Rvcore_data_o,
    output busy_o, err_o
  );

  modport slave (
    output i_req_i, i_addr_i, d_req_i, d_rw_i, d_addr_i, d_wdata_i,
    output axi_data_i, axi_rd_over_i, axi_wr_over_i,
    input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o,
    input  Rvcore_valid_req_o, Rvcore_rw_o, Rvcore_addr_o, Rvcore_data_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/line_arb_grant.sv
// Grant selection between I and D ports: combinational, fixed D-over-I by default.
// LINE_ARB_RR_EN adds a round-robin pointer that flips to the loser on every grant taken.
module line_arb_grant
  import line_req_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   take,
  output logic   any_req,
  output owner_t owner
);

  assign any_req = i_req | d_req;

`ifdef LINE_ARB_RR_EN
  owner_t ptr_q;

  always_comb begin
    owner = OWN_D;
    if (i_req && d_req) begin
      owner = ptr_q;
    end else if (i_req) begin
      owner = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= OWN_I;
    end else if (take && any_req) begin
      ptr_q <= (owner == OWN_I) ? OWN_D : OWN_I;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, take};

  assign owner = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/line_req_arb.sv
// Two-port line arbiter ahead of the AXI master: req->issue pulse 1 cycle, completion->ack 1 cycle.
// No stall path; the losing port holds its req. LINE_ARB_RR_EN selects round-robin over D-over-I.
module line_req_arb
  import line_req_arb_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic           M_AXI_ACLK,
  input  logic           M_AXI_ARESETN,
  line_req_arb_if.master bus
);

  arb_state_t        state_q, state_d;
  owner_t            gnt_owner, owner_q;
  logic              any_req;
  logic              take;
  logic              rw_q;
  logic              err_q;
  logic              rd_match, wr_match, err_evt;
  logic [ADDR_W-1:0] addr_q, req_addr;
  logic [LINE_W-1:0] wdata_q, line_q;

  assign take = (state_q == IDLE);

  line_arb_grant u_grant (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .i_req   (bus.i_req_i),
    .d_req   (bus.d_req_i),
    .take    (take),
    .any_req (any_req),
    .owner   (gnt_owner)
  );

  assign rd_match = (state_q == WAIT) && (rw_q == RW_READ)  && bus.axi_rd_over_i;
  assign wr_match = (state_q == WAIT) && (rw_q == RW_WRITE) && bus.axi_wr_over_i;
  // Anything other than the one pulse the FSM is waiting for is flagged, ISSUE cycle included
  assign err_evt  = (bus.axi_rd_over_i && !rd_match) || (bus.axi_wr_over_i && !wr_match);

  assign req_addr = (gnt_owner == OWN_D) ? bus.d_addr_i : bus.i_addr_i;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (rd_match || wr_match) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      owner_q <= OWN_I;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take && any_req) begin
        owner_q <= gnt_owner;
        rw_q    <= (gnt_owner == OWN_D) ? bus.d_rw_i : RW_READ;
        addr_q  <= req_addr & LINE_ALIGN_MASK[ADDR_W-1:0];
        wdata_q <= (gnt_owner == OWN_D) ? bus.d_wdata_i : '0;
      end
      if (rd_match) begin
        line_q <= bus.axi_data_i;
      end
      if (err_evt) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.Rvcore_valid_req_o = (state_q == ISSUE);
  assign bus.Rvcore_rw_o        = rw_q;
  assign bus.Rvcore_addr_o      = addr_q;
  assign bus.Rvcore_data_o      = wdata_q;

  assign bus.i_ack_o   = (state_q == DONE) && (owner_q == OWN_I);
  assign bus.d_ack_o   = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.i_rdata_o = bus.i_ack_o ? line_q : '0;
  assign bus.d_rdata_o = (bus.d_ack_o && rw_q == RW_READ) ? line_q : '0;

  assign bus.busy_o = (state_q != IDLE);
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_line_req_arb.sv
// Directed bench for line_req_arb: per-cycle vector table plus hand sequences for multi-cycle cases.
// Contention expectations follow LINE_ARB_RR_EN when it is defined for the build.
module tb_line_req_arb;
  import line_req_arb_pkg::*;

  localparam int LW = 128;
  localparam int AW = 32;

  localparam logic [31:0]  A_I  = 32'h0000_1234;
  localparam logic [31:0]  A_IA = 32'h0000_1230;
  localparam logic [31:0]  A_D  = 32'h8000_0040;
  localparam logic [31:0]  A_M  = 32'h0000_2008;
  localparam logic [31:0]  A_MA = 32'h0000_2000;
  localparam logic [31:0]  A_CI = 32'h0000_0100;
  localparam logic [31:0]  A_CD = 32'h0000_0200;
  localparam logic [127:0] RD1  = 128'hCAFE_F00D_0000_0000_1111_2222_DEAD_BEEF;
  localparam logic [127:0] RD2  = 128'h5555_AAAA_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] WD   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  line_req_arb_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  line_req_arb #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic         drw;
    logic [31:0]  da;
    logic [127:0] dw;
    logic         rdo;
    logic         wro;
    logic [127:0] ad;
    logic [37:0]  ectl;
    logic [127:0] ewd;
    logic [127:0] eir;
    logic [127:0] edr;
  } vec_t;

  vec_t tbl[$];

  int          pulse_cyc[$];
  logic [31:0] pulse_addr[$];
  int          ack_i_cnt;
  int          ack_d_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // {valid_req, rw, addr, i_ack, d_ack, busy, err}
  function automatic logic [37:0] ectl(logic vld, logic rw, logic [31:0] a,
                                       logic ia, logic da, logic bz, logic er);
    return {vld, rw, a, ia, da, bz, er};
  endfunction

  function automatic logic [37:0] ctl_now();
    return {bus.Rvcore_valid_req_o, bus.Rvcore_rw_o, bus.Rvcore_addr_o,
            bus.i_ack_o, bus.d_ack_o, bus.busy_o, bus.err_o};
  endfunction

  function automatic vec_t mk(string n, logic ir, logic [31:0] ia, logic dr, logic drw,
                              logic [31:0] da, logic [127:0] dw, logic rdo, logic wro,
                              logic [127:0] ad, logic [37:0] ec, logic [127:0] ewd,
                              logic [127:0] eir, logic [127:0] edr);
    vec_t v;
    v.name = n; v.ir = ir; v.ia = ia; v.dr = dr; v.drw = drw; v.da = da; v.dw = dw;
    v.rdo = rdo; v.wro = wro; v.ad = ad; v.ectl = ec; v.ewd = ewd; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_req_i = 1'b0; bus.i_addr_i = '0;
    bus.d_req_i = 1'b0; bus.d_rw_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.axi_data_i = '0; bus.axi_rd_over_i = 1'b0; bus.axi_wr_over_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requesters re-raise until their quota is acked; the AXI model completes in the first WAIT cycle.
  task automatic run_traffic(input int n_i, input int n_d);
    int   ri = n_i;
    int   rd = n_d;
    int   cyc = 0;
    logic resp = 1'b0;
    logic seen_vld = 1'b0;
    pulse_cyc.delete();
    pulse_addr.delete();
    ack_i_cnt = 0;
    ack_d_cnt = 0;
    while ((ri > 0 || rd > 0 || bus.busy_o) && cyc < 200) begin
      @(negedge clk);
      bus.i_req_i = (ri > 0); bus.i_addr_i = A_CI;
      bus.d_req_i = (rd > 0); bus.d_rw_i = RW_READ; bus.d_addr_i = A_CD;
      bus.axi_rd_over_i = resp;
      bus.axi_data_i = {96'h0, 32'(cyc)};
      @(posedge clk); #1;
      cyc++;
      resp = seen_vld;
      seen_vld = bus.Rvcore_valid_req_o;
      if (bus.Rvcore_valid_req_o) begin
        pulse_cyc.push_back(cyc);
        pulse_addr.push_back(bus.Rvcore_addr_o);
      end
      if (bus.i_ack_o) begin ack_i_cnt++; ri--; end
      if (bus.d_ack_o) begin ack_d_cnt++; rd--; end
    end
    @(negedge clk);
    idle_inputs();
    chk("traffic_timeout", 128'(cyc >= 200), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_order[$];
    idle_inputs();
    #2 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl",   128'(ctl_now()), 128'(0));
    chk("reset_wdata", bus.Rvcore_data_o, 128'(0));
    chk("reset_irdat", bus.i_rdata_o, 128'(0));
    chk("reset_drdat", bus.d_rdata_o, 128'(0));
    rst_n = 1'b1;

    // I read, D write with changing wdata input, D read with a mismatched pulse in WAIT
    tbl.push_back(mk("i_issue", 1, A_I, 0, 0, 0, 0, 0, 0, 0, ectl(1,1,A_IA,0,0,1,0), 0, 0, 0));
    tbl.push_back(mk("i_wait",  1, A_I, 0, 0, 0, 0, 0, 0, 0, ectl(0,1,A_IA,0,0,1,0), 0, 0, 0));
    tbl.push_back(mk("i_done",  1, A_I, 0, 0, 0, 0, 1, 0, RD1, ectl(0,1,A_IA,1,0,1,0), 0, RD1, 0));
    tbl.push_back(mk("i_idle",  0, 0,   0, 0, 0, 0, 0, 0, 0, ectl(0,1,A_IA,0,0,0,0), 0, 0, 0));
    tbl.push_back(mk("d_issue", 0, 0, 1, 0, A_D, WD,  0, 0, 0, ectl(1,0,A_D,0,0,1,0), WD, 0, 0));
    tbl.push_back(mk("d_wait",  0, 0, 1, 0, A_D, ~WD, 0, 0, 0, ectl(0,0,A_D,0,0,1,0), WD, 0, 0));
    tbl.push_back(mk("d_wait2", 0, 0, 1, 0, A_D, ~WD, 0, 0, 0, ectl(0,0,A_D,0,0,1,0), WD, 0, 0));
    tbl.push_back(mk("d_done",  0, 0, 1, 0, A_D, ~WD, 0, 1, 0, ectl(0,0,A_D,0,1,1,0), WD, 0, 0));
    tbl.push_back(mk("d_idle",  0, 0, 0, 0, 0, 0,     0, 0, 0, ectl(0,0,A_D,0,0,0,0), WD, 0, 0));
    tbl.push_back(mk("m_issue", 0, 0, 1, 1, A_M, 0, 0, 0, 0,   ectl(1,1,A_MA,0,0,1,0), 0, 0, 0));
    tbl.push_back(mk("m_wait",  0, 0, 1, 1, A_M, 0, 0, 0, 0,   ectl(0,1,A_MA,0,0,1,0), 0, 0, 0));
    tbl.push_back(mk("m_badwr", 0, 0, 1, 1, A_M, 0, 0, 1, 0,   ectl(0,1,A_MA,0,0,1,1), 0, 0, 0));
    tbl.push_back(mk("m_done",  0, 0, 1, 1, A_M, 0, 1, 0, RD2, ectl(0,1,A_MA,0,1,1,1), 0, 0, RD2));
    tbl.push_back(mk("m_idle",  0, 0, 0, 0, 0,   0, 0, 0, 0,   ectl(0,1,A_MA,0,0,0,1), 0, 0, 0));

    foreach (tbl[k]) begin
      @(negedge clk);
      bus.i_req_i = tbl[k].ir;  bus.i_addr_i = tbl[k].ia;
      bus.d_req_i = tbl[k].dr;  bus.d_rw_i = tbl[k].drw;
      bus.d_addr_i = tbl[k].da; bus.d_wdata_i = tbl[k].dw;
      bus.axi_rd_over_i = tbl[k].rdo; bus.axi_wr_over_i = tbl[k].wro;
      bus.axi_data_i = tbl[k].ad;
      @(posedge clk); #1;
      chk({tbl[k].name, "_ctl"},   128'(ctl_now()), 128'(tbl[k].ectl));
      chk({tbl[k].name, "_wdata"}, bus.Rvcore_data_o, tbl[k].ewd);
      chk({tbl[k].name, "_irdat"}, bus.i_rdata_o, tbl[k].eir);
      chk({tbl[k].name, "_drdat"}, bus.d_rdata_o, tbl[k].edr);
    end

    // Contention with both ports requesting
    do_reset();
`ifdef LINE_ARB_RR_EN
    exp_order = '{A_CI, A_CD, A_CI, A_CD};
    run_traffic(2, 2);
`else
    exp_order = '{A_CD, A_CI};
    run_traffic(1, 1);
`endif
    chk("cont_pulses", 128'(pulse_addr.size()), 128'(exp_order.size()));
    foreach (exp_order[k]) begin
      if (k < pulse_addr.size()) chk($sformatf("cont_order%0d", k), 128'(pulse_addr[k]), 128'(exp_order[k]));
    end
    chk("cont_acks", 128'(ack_i_cnt + ack_d_cnt), 128'(exp_order.size()));

    // Back-to-back D reads with zero-latency completion
    run_traffic(0, 3);
    chk("b2b_pulses", 128'(pulse_cyc.size()), 128'(3));
    chk("b2b_acks",   128'(ack_d_cnt), 128'(3));
    for (int k = 1; k < pulse_cyc.size(); k++) begin
      chk($sformatf("b2b_gap%0d", k), 128'(pulse_cyc[k] - pulse_cyc[k-1] - 1), 128'(3));
    end
    chk("b2b_err", 128'(bus.err_o), 128'(0));

    // Completion pulse during ISSUE is unexpected; the read still completes later
    @(negedge clk);
    bus.i_req_i = 1'b1; bus.i_addr_i = A_CI;
    @(posedge clk); #1;
    chk("iss_pulse", 128'(ctl_now()), 128'(ectl(1,1,A_CI,0,0,1,0)));
    @(negedge clk);
    bus.axi_rd_over_i = 1'b1; bus.axi_data_i = RD2;
    @(posedge clk); #1;
    chk("iss_err", 128'(ctl_now()), 128'(ectl(0,1,A_CI,0,0,1,1)));
    @(negedge clk);
    bus.axi_data_i = RD1;
    @(posedge clk); #1;
    chk("iss_done",  128'(ctl_now()), 128'(ectl(0,1,A_CI,1,0,1,1)));
    chk("iss_rdata", bus.i_rdata_o, RD1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("iss_idle", 128'(ctl_now()), 128'(ectl(0,1,A_CI,0,0,0,1)));

    // Asynchronous reset while waiting on a D read
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.d_rw_i = RW_READ; bus.d_addr_i = A_CD;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_pre_busy", 128'(bus.busy_o), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    bus.d_req_i = 1'b0;
    #1;
    chk("rst_mid_ctl", 128'(ctl_now()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_traffic(1, 0);
    chk("rst_after_pulses", 128'(pulse_addr.size()), 128'(1));
    if (pulse_addr.size() > 0) chk("rst_after_addr", 128'(pulse_addr[0]), 128'(A_CI));
    chk("rst_after_ack", 128'(ack_i_cnt), 128'(1));
    chk("rst_after_err", 128'(bus.err_o), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
